// File: rtl/mdu_unit_pkg.sv
// Shared constants for the multiply/divide unit: op codes, FSM states and op-class helpers.
package mdu_unit_pkg;

    localparam int unsigned MDU_OP_W = 4;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_NOP   = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MADD  = 4'd5,
        MDU_MADDU = 4'd6,
        MDU_MSUB  = 4'd7,
        MDU_MSUBU = 4'd8,
        MDU_MTHI  = 4'd9,
        MDU_MTLO  = 4'd10
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Multiply-class ops share the multiply latency; accumulate variants included.
    function automatic logic is_mul_op(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MULT)  || (op == MDU_MULTU) ||
               (op == MDU_MADD)  || (op == MDU_MADDU) ||
               (op == MDU_MSUB)  || (op == MDU_MSUBU);
    endfunction

    function automatic logic is_div_op(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV) ||
               (op == MDU_MADD) || (op == MDU_MSUB);
    endfunction

endpackage

// File: rtl/mdu_latency_counter.sv
// Down-counter timing a multi-cycle op; last flags the final busy cycle (count == 1).
module mdu_latency_counter #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic          cancel,
    input  logic [CW-1:0] load_val,
    output logic          last
);

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count;
        if (cancel) begin
            count_next = '0;
        end else if (load) begin
            count_next = load_val;
        end else if (count != '0) begin
            count_next = count - CW'(1);
        end
    end

    // last is registered alongside the count so it carries no input path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            last  <= 1'b0;
        end else begin
            count <= count_next;
            last  <= (count_next == CW'(1));
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, accumulate modes and cancel.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] MduOp,
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    input  logic                cancel,
    output logic                busy,
    output logic [WIDTH-1:0]    Hi,
    output logic [WIDTH-1:0]    Lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
    localparam int unsigned DW         = 2 * WIDTH;

    mdu_state_e          state;
    mdu_state_e          state_next;
    logic                accept_c;
    logic                load_c;
    logic                commit_c;
    logic                last;
    logic [CW-1:0]       load_val_c;

    logic [MDU_OP_W-1:0] op_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;

    logic                sgn_c;
    logic [DW-1:0]       a_ext_c;
    logic [DW-1:0]       b_ext_c;
    logic [DW-1:0]       prod_c;
    logic [DW-1:0]       mul_res_c;
    logic                a_neg_c;
    logic                b_neg_c;
    logic [WIDTH-1:0]    a_mag_c;
    logic [WIDTH-1:0]    b_mag_c;
    logic [WIDTH-1:0]    q_mag_c;
    logic [WIDTH-1:0]    r_mag_c;
    logic [WIDTH-1:0]    quot_c;
    logic [WIDTH-1:0]    rem_c;
    logic [DW-1:0]       result_c;

    mdu_latency_counter #(
        .CW(CW)
    ) u_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load_c),
        .cancel   (cancel),
        .load_val (load_val_c),
        .last     (last)
    );

    // State register; busy mirrors the next state so it is a plain flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == ST_RUN);
        end
    end

    // Next-state and control decode; cancel beats completion on the same edge.
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        commit_c   = 1'b0;
        load_val_c = CW'(MULT_CYCLES);
        accept_c   = start & ~busy & ~cancel;
        if (is_div_op(MduOp)) begin
            load_val_c = CW'(DIV_CYCLES);
        end
        case (state)
            ST_IDLE: begin
                if (accept_c && (is_mul_op(MduOp) || is_div_op(MduOp))) begin
                    load_c     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    state_next = ST_IDLE;
                end else if (last) begin
                    state_next = ST_IDLE;
                    commit_c   = ~(is_div_op(op_q) && (b_q == '0));
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand latch at the accepting edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (load_c) begin
            op_q <= MduOp;
            a_q  <= A;
            b_q  <= B;
        end
    end

    // Multiply: sign/zero-extend to 2*WIDTH so one multiplier serves both flavours.
    always_comb begin
        sgn_c     = is_signed_op(op_q);
        a_ext_c   = {{WIDTH{sgn_c & a_q[WIDTH-1]}}, a_q};
        b_ext_c   = {{WIDTH{sgn_c & b_q[WIDTH-1]}}, b_q};
        prod_c    = a_ext_c * b_ext_c;
        mul_res_c = prod_c;
        if ((op_q == MDU_MADD) || (op_q == MDU_MADDU)) begin
            mul_res_c = {Hi, Lo} + prod_c;
        end else if ((op_q == MDU_MSUB) || (op_q == MDU_MSUBU)) begin
            mul_res_c = {Hi, Lo} - prod_c;
        end
    end

    // Divide on magnitudes, then restore signs; the overflow case falls out naturally.
    always_comb begin
        a_neg_c = sgn_c & a_q[WIDTH-1];
        b_neg_c = sgn_c & b_q[WIDTH-1];
        a_mag_c = a_neg_c ? (~a_q + WIDTH'(1)) : a_q;
        b_mag_c = b_neg_c ? (~b_q + WIDTH'(1)) : b_q;
        q_mag_c = '0;
        r_mag_c = '0;
        if (b_mag_c != '0) begin
            q_mag_c = a_mag_c / b_mag_c;
            r_mag_c = a_mag_c % b_mag_c;
        end
        quot_c   = (a_neg_c ^ b_neg_c) ? (~q_mag_c + WIDTH'(1)) : q_mag_c;
        rem_c    = a_neg_c ? (~r_mag_c + WIDTH'(1)) : r_mag_c;
        result_c = is_div_op(op_q) ? {rem_c, quot_c} : mul_res_c;
    end

    // HI/LO: commit from a finished op, or a direct move at the accepting edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Hi <= '0;
            Lo <= '0;
        end else if (commit_c) begin
            Hi <= result_c[DW-1:WIDTH];
            Lo <= result_c[WIDTH-1:0];
        end else if (accept_c && (MduOp == MDU_MTHI)) begin
            Hi <= A;
        end else if (accept_c && (MduOp == MDU_MTLO)) begin
            Lo <= A;
        end
    end

endmodule
